lc3_controller: RTL and testbench
=================================

// Module: lc3_controller
// PURPOSE
//  Sequencing FSM of the LC3 core. Sits directly upstream of fetch and drives
//  the cntrl_e state, br_taken and rst seen on fetch_ifc.
//  - Walks each instruction through UPDATE_PC/FETCH/DECODE/EXECUTE and the
//    memory/PC sub-states chosen by opcode.
//  - Stalls on memory handshakes.
//  - Counts retired instructions.
// PARAMETERS
//  CNT_W        16   width of retire counter (wraps modulo 2**CNT_W)
//  MEM_WAIT_EN  1    1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  rst          in   1      asynchronous, active-low reset
//  instr_dout   in   16     instruction word from memory; sampled in CNTRL_FETCH when mem_ready=1
//  psr          in   3      NZP flags from writeback; sampled in CNTRL_COMPUTE_PC
//  mem_ready    in   1      memory access complete (FETCH/IND_ADDR_RD/READ_MEM/WRITE_MEM)
//  state        out  cntrl_e  current controller state (to fetch, decode, execute, writeback)
//  br_taken     out  1      fetch selects taddr instead of npc; valid in CNTRL_UPDATE_PC
//  illegal_op   out  1      1-cycle pulse: unsupported opcode was decoded
//  retire_cnt   out  CNT_W  number of CNTRL_UPDATE_PC cycles since reset
// BEHAVIOUR
//  Reset (rst=0, async, takes effect immediately, even mid-instruction):
//   state=CNTRL_FETCH, br_taken=0, illegal_op=0, retire_cnt=0, ir=16'h0.
//  ir[15:0]: internal copy of instr_dout, loaded on the FETCH->DECODE edge.
//  Opcode groups (ir[15:12]):
//   ALU   = ADD 0001, AND 0101, NOT 1001, LEA 1110
//   CTRL  = BR 0000, JMP 1100
//   LOAD  = LD 0010, LDR 0110
//   LDI   = 1010
//   STORE = ST 0011, STR 0111
//   STI   = 1011
//   ILLEGAL = 0100, 1000, 1101, 1111
//  Transitions (one per clock unless waiting):
//   UPDATE_PC   -> FETCH
//   FETCH       -> DECODE when mem_ready, else hold
//   DECODE      -> EXECUTE if legal; -> UPDATE_PC if ILLEGAL (illegal_op=1 during that UPDATE_PC)
//   EXECUTE     -> UPDATE_REGF (ALU) | COMPUTE_PC (CTRL) | COMPUTE_MEM (LOAD/LDI/STORE/STI)
//   COMPUTE_MEM -> READ_MEM (LOAD) | IND_ADDR_RD (LDI/STI) | WRITE_MEM (STORE)
//   IND_ADDR_RD -> READ_MEM (LDI) | WRITE_MEM (STI) when mem_ready, else hold
//   READ_MEM    -> UPDATE_REGF when mem_ready, else hold
//   WRITE_MEM   -> UPDATE_PC when mem_ready, else hold
//   UPDATE_REGF -> UPDATE_PC
//   COMPUTE_PC  -> UPDATE_PC
//  br_taken:
//   - Registered on the COMPUTE_PC->UPDATE_PC edge:
//     BR = |(ir[11:9] & psr); JMP = 1.
//   - Held for the UPDATE_PC cycle; cleared on the edge leaving UPDATE_PC.
//   - 0 in all other states.
//  retire_cnt: +1 on every clock edge where state==UPDATE_PC (illegal included); wraps to 0.
//  Latency (mem_ready=1, counted from FETCH to UPDATE_PC inclusive):
//   ALU=5, CTRL=5, STORE=6, LOAD=7, STI=7, LDI=8, ILLEGAL=3.
//  mem_ready asserted in a non-waiting state is ignored; no stored credit.
//  instr_dout changes while FETCH is stalled are ignored; only the value at the mem_ready edge is latched.
//  psr at ir[11:9]=000 (BR never) -> br_taken=0.
// TESTING
//  1 Reset: drop rst mid-READ_MEM -> same cycle state=FETCH, br_taken=0, retire_cnt=0.
//  2 ADD 16'h1042, mem_ready=1 -> states FETCH,DECODE,EXECUTE,UPDATE_REGF,UPDATE_PC; retire_cnt 0->1.
//  3 BRz 16'h0405 with psr=3'b010 -> br_taken=1 only in UPDATE_PC;
//    same instruction with psr=3'b100 -> br_taken=0.
//  4 LDI 16'hA203, mem_ready low 3 cycles in IND_ADDR_RD -> holds 3 cycles, then READ_MEM, UPDATE_REGF.
//  5 Opcode 16'hD000 -> FETCH,DECODE,UPDATE_PC; illegal_op=1 for exactly 1 cycle.
//  6 CNT_W=4, run 16 ADDs -> retire_cnt wraps 15->0; STI 16'hB000 path = 7 cycles.

Source files
------------

// File: rtl/lc3_controller.sv
// LC3 sequencing controller: walks each instruction through fetch, decode,
// execute and the opcode-specific memory/PC sub-states, and counts retirements.

package lc3_pkg;
    typedef enum logic [3:0] {
        CNTRL_FETCH,
        CNTRL_DECODE,
        CNTRL_EXECUTE,
        CNTRL_UPDATE_REGF,
        CNTRL_COMPUTE_PC,
        CNTRL_COMPUTE_MEM,
        CNTRL_IND_ADDR_RD,
        CNTRL_READ_MEM,
        CNTRL_WRITE_MEM,
        CNTRL_UPDATE_PC
    } cntrl_e;
endpackage

module lc3_controller
    import lc3_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr_dout,
    input  logic [2:0]       psr,
    input  logic             mem_ready,
    output cntrl_e           state,
    output logic             br_taken,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retire_cnt
);

    // Memory handshake: a waiting state (FETCH, IND_ADDR_RD, READ_MEM,
    // WRITE_MEM) advances only on a clock edge where mem_ready is high.
    // mem_ready seen in any other state is dropped; no credit is stored.
    logic        mem_ok;
    logic [15:0] ir;
    logic [3:0]  op;
    cntrl_e      state_d;
    logic        is_alu, is_ctrl, is_load, is_ldi, is_store, is_sti, is_illegal;
    logic        br_d;
    logic        ir_unused;

    assign mem_ok    = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign op        = ir[15:12];
    // Offset/register fields belong to the datapath, not to sequencing.
    assign ir_unused = ^ir[8:0];
    // Only CTRL opcodes reach COMPUTE_PC, so JMP vs. BR is all that matters.
    assign br_d      = (op == 4'b1100) | (|(ir[11:9] & psr));

    always_comb begin
        is_alu     = 1'b0;
        is_ctrl    = 1'b0;
        is_load    = 1'b0;
        is_ldi     = 1'b0;
        is_store   = 1'b0;
        is_sti     = 1'b0;
        is_illegal = 1'b0;
        case (op)
            4'b0001, 4'b0101, 4'b1001, 4'b1110: is_alu   = 1'b1;
            4'b0000, 4'b1100:                   is_ctrl  = 1'b1;
            4'b0010, 4'b0110:                   is_load  = 1'b1;
            4'b1010:                            is_ldi   = 1'b1;
            4'b0011, 4'b0111:                   is_store = 1'b1;
            4'b1011:                            is_sti   = 1'b1;
            default:                            is_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            CNTRL_UPDATE_PC:   state_d = CNTRL_FETCH;
            CNTRL_FETCH:       if (mem_ok) state_d = CNTRL_DECODE;
            CNTRL_DECODE:      state_d = is_illegal ? CNTRL_UPDATE_PC : CNTRL_EXECUTE;
            CNTRL_EXECUTE: begin
                if (is_alu)       state_d = CNTRL_UPDATE_REGF;
                else if (is_ctrl) state_d = CNTRL_COMPUTE_PC;
                else              state_d = CNTRL_COMPUTE_MEM;
            end
            CNTRL_COMPUTE_MEM: begin
                if (is_load)       state_d = CNTRL_READ_MEM;
                else if (is_store) state_d = CNTRL_WRITE_MEM;
                else               state_d = CNTRL_IND_ADDR_RD;
            end
            CNTRL_IND_ADDR_RD: if (mem_ok) state_d = is_sti ? CNTRL_WRITE_MEM : CNTRL_READ_MEM;
            CNTRL_READ_MEM:    if (mem_ok) state_d = CNTRL_UPDATE_REGF;
            CNTRL_WRITE_MEM:   if (mem_ok) state_d = CNTRL_UPDATE_PC;
            CNTRL_UPDATE_REGF: state_d = CNTRL_UPDATE_PC;
            CNTRL_COMPUTE_PC:  state_d = CNTRL_UPDATE_PC;
            default:           state_d = CNTRL_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= CNTRL_FETCH;
            ir         <= 16'h0;
            br_taken   <= 1'b0;
            illegal_op <= 1'b0;
            retire_cnt <= '0;
        end else begin
            state      <= state_d;
            if (state == CNTRL_FETCH && mem_ok)
                ir <= instr_dout;
            br_taken   <= (state == CNTRL_COMPUTE_PC) && br_d;
            illegal_op <= (state == CNTRL_DECODE) && is_illegal;
            if (state == CNTRL_UPDATE_PC)
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lc3_controller.sv
// Bench for lc3_controller: directed vector table, hand-written reset/wrap
// sequences, and random instructions with random memory stalls.

module tb_lc3_controller;
    import lc3_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [15:0]      instr_dout;
    logic [2:0]       psr;
    logic             mem_ready;
    cntrl_e           state;
    logic             br_taken;
    logic             illegal_op;
    logic [CNT_W-1:0] retire_cnt;

    int     total = 0;
    int     bad = 0;
    int     exp_cnt = 0;
    cntrl_e exp_q[$];

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  psr;
        int          mode;  // 0: mem_ready=1, 1: random, 2: 3-cycle stall in IND_ADDR_RD
        int          len;
        logic        br;
        int          ill;
    } vec_t;
    vec_t vecs[$];

    lc3_controller #(.CNT_W(CNT_W), .MEM_WAIT_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_dout (instr_dout),
        .psr        (psr),
        .mem_ready  (mem_ready),
        .state      (state),
        .br_taken   (br_taken),
        .illegal_op (illegal_op),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_state(input string name, input cntrl_e act, input cntrl_e req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: state %s expected %s at %0t", name, act.name(), req.name(), $time);
        end
    endtask

    task automatic add_vec(input logic [15:0] i, input logic [2:0] p, input int m,
                           input int l, input logic b, input int il);
        vec_t v;
        v.instr = i; v.psr = p; v.mode = m; v.len = l; v.br = b; v.ill = il;
        vecs.push_back(v);
    endtask

    function automatic bit is_illegal(input logic [3:0] op);
        return op == 4'b0100 || op == 4'b1000 || op == 4'b1101 || op == 4'b1111;
    endfunction

    function automatic logic exp_br(input logic [15:0] instr, input logic [2:0] p);
        if (instr[15:12] == 4'b1100) return 1'b1;
        if (instr[15:12] == 4'b0000) return |(instr[11:9] & p);
        return 1'b0;
    endfunction

    function automatic bit waits(input cntrl_e s);
        return s == CNTRL_FETCH || s == CNTRL_IND_ADDR_RD || s == CNTRL_READ_MEM || s == CNTRL_WRITE_MEM;
    endfunction

    // Expected state walk of one instruction, stalls excluded.
    task automatic build_path(input logic [15:0] instr);
        exp_q.delete();
        exp_q.push_back(CNTRL_FETCH);
        exp_q.push_back(CNTRL_DECODE);
        case (instr[15:12])
            4'b0001, 4'b0101, 4'b1001, 4'b1110: begin
                exp_q.push_back(CNTRL_EXECUTE); exp_q.push_back(CNTRL_UPDATE_REGF);
            end
            4'b0000, 4'b1100: begin
                exp_q.push_back(CNTRL_EXECUTE); exp_q.push_back(CNTRL_COMPUTE_PC);
            end
            4'b0010, 4'b0110: begin
                exp_q.push_back(CNTRL_EXECUTE); exp_q.push_back(CNTRL_COMPUTE_MEM);
                exp_q.push_back(CNTRL_READ_MEM); exp_q.push_back(CNTRL_UPDATE_REGF);
            end
            4'b1010: begin
                exp_q.push_back(CNTRL_EXECUTE); exp_q.push_back(CNTRL_COMPUTE_MEM);
                exp_q.push_back(CNTRL_IND_ADDR_RD); exp_q.push_back(CNTRL_READ_MEM);
                exp_q.push_back(CNTRL_UPDATE_REGF);
            end
            4'b0011, 4'b0111: begin
                exp_q.push_back(CNTRL_EXECUTE); exp_q.push_back(CNTRL_COMPUTE_MEM);
                exp_q.push_back(CNTRL_WRITE_MEM);
            end
            4'b1011: begin
                exp_q.push_back(CNTRL_EXECUTE); exp_q.push_back(CNTRL_COMPUTE_MEM);
                exp_q.push_back(CNTRL_IND_ADDR_RD); exp_q.push_back(CNTRL_WRITE_MEM);
            end
            default: ;
        endcase
        exp_q.push_back(CNTRL_UPDATE_PC);
    endtask

    // Drives one instruction from FETCH to the FETCH after its UPDATE_PC,
    // checking every cycle; returns measured length, br_taken seen in
    // UPDATE_PC and the number of cycles illegal_op was high.
    task automatic run_instr(input logic [15:0] instr, input logic [2:0] p, input int mode,
                             output int cycles, output logic seen_br, output int ill_cnt);
        int   pos = 0;
        int   ind_stalls = 0;
        logic adv, last, ebr;
        bit   eill;
        build_path(instr);
        ebr = exp_br(instr, p);
        eill = is_illegal(instr[15:12]);
        psr = p;
        cycles = 0;
        seen_br = 1'b0;
        ill_cnt = 0;
        check_state("start_state", state, CNTRL_FETCH);
        check("start_br", int'(br_taken), 0);
        while (1) begin
            cycles++;
            if (exp_q[pos] == CNTRL_UPDATE_PC) seen_br = br_taken;
            ill_cnt += int'(illegal_op);
            case (mode)
                0: mem_ready = 1'b1;
                1: mem_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    mem_ready = !(exp_q[pos] == CNTRL_IND_ADDR_RD && ind_stalls < 3);
                    if (!mem_ready) ind_stalls++;
                end
            endcase
            instr_dout = mem_ready ? instr : 16'($urandom);
            adv = !waits(exp_q[pos]) || mem_ready;
            last = (exp_q[pos] == CNTRL_UPDATE_PC);
            @(posedge clk); #1;
            if (last) begin
                exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
                break;
            end
            if (adv) pos++;
            check_state("walk_state", state, exp_q[pos]);
            check("walk_br", int'(br_taken), int'(ebr && exp_q[pos] == CNTRL_UPDATE_PC));
            check("walk_illegal", int'(illegal_op), int'(eill && exp_q[pos] == CNTRL_UPDATE_PC));
            check("walk_retire", int'(retire_cnt), exp_cnt);
            if (cycles > 200) begin
                total++;
                bad++;
                $display("FAIL timeout: instr %h stuck in %s", instr, state.name());
                break;
            end
        end
        mem_ready = 1'b0;
        check_state("end_state", state, CNTRL_FETCH);
        check("end_retire", int'(retire_cnt), exp_cnt);
    endtask

    initial begin
        int   cyc, ill, n;
        logic br;

        mem_ready = 1'b0;
        instr_dout = 16'h0;
        psr = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset_state", state, CNTRL_FETCH);
        check("reset_br", int'(br_taken), 0);
        check("reset_illegal", int'(illegal_op), 0);
        check("reset_retire", int'(retire_cnt), 0);
        rst = 1'b1;

        add_vec(16'h1042, 3'b000, 0, 5, 1'b0, 0);  // ADD
        add_vec(16'h5042, 3'b111, 0, 5, 1'b0, 0);  // AND
        add_vec(16'h907F, 3'b111, 0, 5, 1'b0, 0);  // NOT
        add_vec(16'hE005, 3'b111, 0, 5, 1'b0, 0);  // LEA
        add_vec(16'h0405, 3'b010, 0, 5, 1'b1, 0);  // BRz, Z set
        add_vec(16'h0405, 3'b100, 0, 5, 1'b0, 0);  // BRz, N set
        add_vec(16'h0000, 3'b111, 0, 5, 1'b0, 0);  // BR never
        add_vec(16'h0E00, 3'b001, 0, 5, 1'b1, 0);  // BRnzp
        add_vec(16'hC1C0, 3'b000, 0, 5, 1'b1, 0);  // JMP
        add_vec(16'h3005, 3'b000, 0, 6, 1'b0, 0);  // ST
        add_vec(16'h7041, 3'b000, 0, 6, 1'b0, 0);  // STR
        add_vec(16'h2005, 3'b000, 0, 7, 1'b0, 0);  // LD
        add_vec(16'h6041, 3'b000, 0, 7, 1'b0, 0);  // LDR
        add_vec(16'hB000, 3'b000, 0, 7, 1'b0, 0);  // STI
        add_vec(16'hA203, 3'b000, 0, 8, 1'b0, 0);  // LDI
        add_vec(16'hA203, 3'b000, 2, 11, 1'b0, 0); // LDI, 3 stall cycles
        add_vec(16'hD000, 3'b111, 0, 3, 1'b0, 1);  // illegal opcodes
        add_vec(16'h4000, 3'b111, 0, 3, 1'b0, 1);
        add_vec(16'h8000, 3'b000, 0, 3, 1'b0, 1);
        add_vec(16'hF0FF, 3'b000, 0, 3, 1'b0, 1);

        foreach (vecs[i]) begin
            run_instr(vecs[i].instr, vecs[i].psr, vecs[i].mode, cyc, br, ill);
            check($sformatf("vec%0d_len", i), cyc, vecs[i].len);
            check($sformatf("vec%0d_br", i), int'(br), int'(vecs[i].br));
            check($sformatf("vec%0d_illegal", i), ill, vecs[i].ill);
        end

        // Reset dropped while stalled in READ_MEM.
        instr_dout = 16'h2000;
        mem_ready = 1'b1;
        n = 0;
        while (state != CNTRL_READ_MEM && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check_state("reach_read_mem", state, CNTRL_READ_MEM);
        mem_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check_state("read_mem_hold", state, CNTRL_READ_MEM);
        end
        check("retire_before_reset", int'(retire_cnt), exp_cnt);
        #2 rst = 1'b0;
        #1;
        check_state("async_reset_state", state, CNTRL_FETCH);
        check("async_reset_br", int'(br_taken), 0);
        check("async_reset_retire", int'(retire_cnt), 0);
        exp_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Retire counter wrap with a 4-bit counter.
        repeat (15) run_instr(16'h1042, 3'b000, 0, cyc, br, ill);
        check("retire_at_15", int'(retire_cnt), 15);
        run_instr(16'h1042, 3'b000, 0, cyc, br, ill);
        check("retire_wrap", int'(retire_cnt), 0);

        // Random instructions with random memory stalls.
        repeat (120) begin
            run_instr(16'($urandom), 3'($urandom_range(0, 7)), 1, cyc, br, ill);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
